// File: rtl/uart_rx_packer.sv
// uart_rx_packer
//
// Packs received UART bytes little-endian into 32-bit words and writes each
// word to an Avalon-MM RAM window of DEPTH words. A flush request writes a
// partially filled word with only the filled lanes enabled. The write
// address wraps at DEPTH, and a sticky flag records the wrap.
//
// Optional feature: define UART_RX_PACKER_TIMEOUT_FLUSH_EN to flush a partial
// word automatically after IDLE_TIMEOUT-1 idle cycles. In the default build
// this counter is absent.
//
// Ports
//   clk          single clock
//   reset_n      synchronous, active-low reset
//   rx_valid     received byte available
//   rx_data      received byte
//   rx_ready     byte accepted this cycle (high while collecting)
//   flush        single-cycle request to write a partial word
//   address      word address to the RAM
//   byteenable   lane enables, bit i covers writedata[8i+7:8i]
//   chipselect   Avalon-MM chip select
//   write        Avalon-MM write strobe
//   writedata    packed word
//   waitrequest  RAM stall
//   word_count   words written since reset, saturating
//   wrapped      sticky, set when address wraps from DEPTH-1 to 0

module uart_rx_packer #(
    parameter int DEPTH        = 51200,
    parameter int ADDR_W       = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    output logic [ADDR_W-1:0] word_count,
    output logic              wrapped
);

    // Reject parameter values the counters and address compare cannot hold.
    if (IDLE_TIMEOUT < 2 || IDLE_TIMEOUT > 65535) begin : g_bad_timeout
        $error("uart_rx_packer: IDLE_TIMEOUT must be in 2..65535");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("uart_rx_packer: DEPTH must fit in ADDR_W address bits");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        WRITE   = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_cnt;
    logic [3:0]  lane_en;
    logic [31:0] data_reg;
    logic        accept;
    logic        last_byte;
    logic        timeout_hit;
    logic        start_partial;
    logic        go_write;
    logic        write_done;

    assign accept     = rx_valid && (state == COLLECT);
    assign last_byte  = accept && (byte_cnt == 2'd3);
    // A flush that coincides with an accepted byte still writes, because the
    // byte is stored first and the word is then no longer empty.
    assign start_partial = (state == COLLECT) && (flush || timeout_hit) &&
                           ((byte_cnt != 2'd0) || accept);
    assign go_write   = last_byte || start_partial;
    assign write_done = (state == WRITE) && !waitrequest;

`ifdef UART_RX_PACKER_TIMEOUT_FLUSH_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(IDLE_TIMEOUT - 1);

    logic [15:0] idle_cnt;

    // Counts idle collect cycles while a partial word is waiting; reaching
    // the last count behaves exactly like a flush request.
    assign timeout_hit = (state == COLLECT) && (byte_cnt != 2'd0) && !accept &&
                         (idle_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt <= 16'd0;
        end else if ((state != COLLECT) || accept || go_write) begin
            idle_cnt <= 16'd0;
        end else if (byte_cnt != 2'd0) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a full or flushed word enters WRITE, which is held
    // until the RAM stops stalling.
    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (go_write)   next_state = WRITE;
            WRITE:   if (write_done) next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    // Output logic: bus strobes and lane enables are only visible in WRITE.
    always_comb begin
        rx_ready   = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        byteenable = 4'b0000;
        case (state)
            COLLECT: rx_ready = 1'b1;
            WRITE: begin
                chipselect = 1'b1;
                write      = 1'b1;
                byteenable = lane_en;
            end
            default: rx_ready = 1'b0;
        endcase
    end

    assign writedata = data_reg;

    // Datapath: byte lanes, lane enables, address and statistics. The data
    // register is cleared after each write so unused lanes of a partial
    // word read as zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            byte_cnt   <= 2'd0;
            lane_en    <= 4'b0000;
            data_reg   <= 32'd0;
            address    <= '0;
            word_count <= '0;
            wrapped    <= 1'b0;
        end else begin
            if (accept) begin
                data_reg[{byte_cnt, 3'b000} +: 8] <= rx_data;
                lane_en[byte_cnt]                 <= 1'b1;
            end

            if (go_write) begin
                byte_cnt <= 2'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (write_done) begin
                lane_en  <= 4'b0000;
                data_reg <= 32'd0;
                if (address == ADDR_W'(DEPTH - 1)) begin
                    address <= '0;
                    wrapped <= 1'b1;
                end else begin
                    address <= address + ADDR_W'(1);
                end
                if (word_count != '1) begin
                    word_count <= word_count + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer
//
// Drives uart_rx_packer with directed and random byte streams and compares
// every cycle against a queue-based model of the packing rules. A small
// DEPTH keeps the address-wrap scenario short.

module tb_uart_rx_packer;

    localparam int TB_DEPTH   = 16;
    localparam int TB_ADDR_W  = 16;
    localparam int TB_TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 flush;
    logic [TB_ADDR_W-1:0] address;
    logic [3:0]           byteenable;
    logic                 chipselect;
    logic                 write;
    logic [31:0]          writedata;
    logic                 waitrequest;
    logic [TB_ADDR_W-1:0] word_count;
    logic                 wrapped;

    int checks = 0;
    int errors = 0;
    int write_cycles = 0;

    // Model state: bytes waiting to be packed, the word being written, and
    // the address/statistics the RAM side should show.
    logic [7:0]  m_pending[$];
    bit          m_busy = 1'b0;
    logic [31:0] m_word = 32'd0;
    logic [3:0]  m_be = 4'd0;
    int          m_addr = 0;
    int          m_wc = 0;
    bit          m_wrapped = 1'b0;
    int          m_idle = 0;

    uart_rx_packer #(
        .DEPTH       (TB_DEPTH),
        .ADDR_W      (TB_ADDR_W),
        .IDLE_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .flush      (flush),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .waitrequest(waitrequest),
        .word_count (word_count),
        .wrapped    (wrapped)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model by the
    // rules for the inputs currently applied, then move past the edge.
    task automatic tick();
        bit do_flush;
        bit accepted;
        @(negedge clk);
        if (reset_n) begin
            checkOutput("rx_ready",   32'(rx_ready),   32'(!m_busy));
            checkOutput("write",      32'(write),      32'(m_busy));
            checkOutput("chipselect", 32'(chipselect), 32'(m_busy));
            checkOutput("address",    32'(address),    32'(m_addr));
            checkOutput("word_count", 32'(word_count), 32'(m_wc));
            checkOutput("wrapped",    32'(wrapped),    32'(m_wrapped));
            if (m_busy) begin
                checkOutput("writedata",  writedata,        m_word);
                checkOutput("byteenable", 32'(byteenable),  32'(m_be));
            end else begin
                checkOutput("byteenable_idle", 32'(byteenable), 32'd0);
            end
            if (write) write_cycles++;
        end

        if (!reset_n) begin
            m_pending.delete();
            m_busy    = 1'b0;
            m_word    = 32'd0;
            m_be      = 4'd0;
            m_addr    = 0;
            m_wc      = 0;
            m_wrapped = 1'b0;
            m_idle    = 0;
        end else if (m_busy) begin
            m_idle = 0;
            if (!waitrequest) begin
                m_busy = 1'b0;
                if (m_addr == TB_DEPTH - 1) begin
                    m_addr    = 0;
                    m_wrapped = 1'b1;
                end else begin
                    m_addr++;
                end
                if (m_wc != (2 ** TB_ADDR_W) - 1) m_wc++;
            end
        end else begin
            accepted = rx_valid;
            do_flush = flush;
            if (accepted) begin
                m_pending.push_back(rx_data);
                m_idle = 0;
            end
`ifdef UART_RX_PACKER_TIMEOUT_FLUSH_EN
            if (!accepted && m_pending.size() > 0) begin
                if (m_idle == TB_TIMEOUT - 1) begin
                    do_flush = 1'b1;
                    m_idle   = 0;
                end else begin
                    m_idle++;
                end
            end
`endif
            if (m_pending.size() == 4 || (do_flush && m_pending.size() > 0)) begin
                m_word = 32'd0;
                m_be   = 4'd0;
                foreach (m_pending[i]) begin
                    m_word[8*i +: 8] = m_pending[i];
                    m_be[i]          = 1'b1;
                end
                m_pending.delete();
                m_busy = 1'b1;
                m_idle = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs and run it through the model.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit f, input bit w);
        rx_valid    = v;
        rx_data     = d;
        flush       = f;
        waitrequest = w;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, w[8*i +: 8], 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Directed scenarios followed by a random stream and the wrap case.
    initial begin
        reset_n     = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        flush       = 1'b0;
        waitrequest = 1'b0;
        doReset();
        idle(1);

        // Full word back-to-back.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
        checkOutput("full_write_addr", 32'(address), 32'd0);
        checkOutput("full_writedata",  writedata, 32'h44332211);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("full_word_count", 32'(word_count), 32'd1);

        // Partial word via flush, plus ignored flushes.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("partial_writedata", writedata, 32'h0000BBAA);
        checkOutput("partial_be", 32'(byteenable), 32'h3);
        idle(2);

        // Stalled write: four cycles held, flush during WRITE ignored.
        write_cycles = 0;
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC4, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        checkOutput("stall_write_cycles", 32'(write_cycles), 32'd4);
        checkOutput("stall_addr", 32'(address), 32'd3);

        // Flush coinciding with a byte acceptance.
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b0);
        checkOutput("flush_accept_data", writedata, 32'h00030201);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        write_cycles = 0;
        applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h06, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b0);
        idle(3);
        checkOutput("flush_4th_single", 32'(write_cycles), 32'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit f;
            v = 1'($urandom_range(0, 1));
            f = !v && ($urandom_range(0, 9) == 0);
            applyStimulus(v, 8'($urandom), f, $urandom_range(0, 3) == 0);
        end
        idle(3);

        // Idle timeout on a single byte.
        write_cycles = 0;
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(14);
`ifdef UART_RX_PACKER_TIMEOUT_FLUSH_EN
        checkOutput("timeout_writes", 32'(write_cycles), 32'd1);
`else
        checkOutput("timeout_writes", 32'(write_cycles), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
`endif

        // Reset during a stalled write.
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE4, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("reset_abort_addr", 32'(address), 32'd0);
        checkOutput("reset_abort_wc", 32'(word_count), 32'd0);

        // Address wrap.
        for (int i = 0; i < TB_DEPTH - 1; i++) sendWord($urandom);
        checkOutput("pre_wrap_addr", 32'(address), 32'(TB_DEPTH - 1));
        checkOutput("pre_wrap_flag", 32'(wrapped), 32'd0);
        sendWord(32'hDEADBEEF);
        checkOutput("wrap_addr", 32'(address), 32'd0);
        checkOutput("wrap_flag", 32'(wrapped), 32'd1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
